vp_feedback_tracker: RTL and testbench

VP_FEEDBACK_TRACKER -- requirements
Module: vp_feedback_tracker

---
 rtl/vp_feedback_tracker.sv | 155 +++++++++++++++
 tb/tb_vp_feedback_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vp_feedback_tracker.sv
// Value-prediction feedback tracker: tracks issued predictions in order and
// reports each prediction's outcome to the predictor on in-order execution.
module vp_feedback_tracker #(
  parameter int P_DEPTH            = 16,
  parameter int P_CONF_THRES_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [31:0]                   pred_pc_i,
  input  logic [31:0]                   pred_result_i,
  input  logic [P_CONF_THRES_WIDTH-1:0] pred_conf_i,
  input  logic                          pred_valid_i,
  input  logic                          alloc_i,
  output logic                          alloc_ready_o,
  input  logic [31:0]                   ex_pc_i,
  input  logic [31:0]                   ex_actual_i,
  input  logic                          ex_valid_i,
  output logic [31:0]                   fb_pc_o,
  output logic [31:0]                   fb_actual_o,
  output logic [P_CONF_THRES_WIDTH-1:0] fb_conf_o,
  output logic                          fb_mispredict_o,
  output logic                          fb_valid_o,
  output logic                          flush_o,
  output logic [$clog2(P_DEPTH):0]      count_o,
  output logic                          err_o,
  output logic [31:0]                   pred_cnt_o,
  output logic [31:0]                   mispred_cnt_o
);

  localparam int P_PTR_WIDTH = $clog2(P_DEPTH);
  localparam logic [P_PTR_WIDTH:0]   LP_FULL    = (P_PTR_WIDTH+1)'(P_DEPTH);
  localparam logic [P_PTR_WIDTH:0]   LP_CNT_ONE = (P_PTR_WIDTH+1)'(1);
  localparam logic [P_PTR_WIDTH-1:0] LP_PTR_ONE = P_PTR_WIDTH'(1);
  localparam logic [31:0]            LP_SAT     = 32'hFFFF_FFFF;

  logic [31:0]                   r_pc_mem     [P_DEPTH];
  logic [31:0]                   r_result_mem [P_DEPTH];
  logic [P_CONF_THRES_WIDTH-1:0] r_conf_mem   [P_DEPTH];
  logic                          r_used_mem   [P_DEPTH];

  logic [P_PTR_WIDTH-1:0]        r_head;
  logic [P_PTR_WIDTH-1:0]        r_tail;
  logic [P_PTR_WIDTH:0]          r_count;
  logic [31:0]                   r_fb_pc;
  logic [31:0]                   r_fb_actual;
  logic [P_CONF_THRES_WIDTH-1:0] r_fb_conf;
  logic                          r_fb_mispredict;
  logic                          r_fb_valid;
  logic                          r_flush;
  logic                          r_err;
  logic [31:0]                   r_pred_cnt;
  logic [31:0]                   r_mispred_cnt;

  logic                          w_alloc_ready;
  logic                          w_alloc_fire;
  logic                          w_retire;
  logic                          w_head_used;
  logic                          w_mispred;
  logic                          w_err_set;
  logic [P_PTR_WIDTH-1:0]        w_tail_nxt;

  assign w_alloc_ready = (r_count != LP_FULL) && !r_flush;
  assign w_alloc_fire  = alloc_i && w_alloc_ready;
  assign w_retire      = ex_valid_i && (r_count != '0);
  assign w_head_used   = r_used_mem[r_head];
  assign w_mispred     = w_retire && w_head_used && (r_result_mem[r_head] != ex_actual_i);
  assign w_err_set     = (ex_valid_i && (r_count == '0)) ||
                         (w_retire && (ex_pc_i != r_pc_mem[r_head]));
  assign w_tail_nxt    = w_alloc_fire ? r_tail + LP_PTR_ONE : r_tail;

  // Entry storage is deliberately left unreset; only pointers qualify it.
  always_ff @(posedge clk_i) begin
    if (w_alloc_fire) begin
      r_pc_mem[r_tail]     <= pred_pc_i;
      r_result_mem[r_tail] <= pred_result_i;
      r_conf_mem[r_tail]   <= pred_conf_i;
      r_used_mem[r_tail]   <= pred_valid_i;
    end
  end

  // A used misprediction squashes everything younger, including a same-cycle alloc.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail <= w_tail_nxt;
      if (w_mispred) begin
        r_head  <= w_tail_nxt;
        r_count <= '0;
      end else begin
        if (w_retire) begin
          r_head <= r_head + LP_PTR_ONE;
        end
        unique case ({w_alloc_fire, w_retire})
          2'b10:   r_count <= r_count + LP_CNT_ONE;
          2'b01:   r_count <= r_count - LP_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fb_pc         <= '0;
      r_fb_actual     <= '0;
      r_fb_conf       <= '0;
      r_fb_mispredict <= 1'b0;
      r_fb_valid      <= 1'b0;
      r_flush         <= 1'b0;
    end else begin
      r_fb_valid      <= w_retire;
      r_fb_mispredict <= w_mispred;
      r_flush         <= w_mispred;
      if (w_retire) begin
        r_fb_pc     <= r_pc_mem[r_head];
        r_fb_actual <= ex_actual_i;
        r_fb_conf   <= r_conf_mem[r_head];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err         <= 1'b0;
      r_pred_cnt    <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_retire && w_head_used && (r_pred_cnt != LP_SAT)) begin
        r_pred_cnt <= r_pred_cnt + 32'd1;
      end
      if (w_mispred && (r_mispred_cnt != LP_SAT)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign alloc_ready_o   = w_alloc_ready;
  assign fb_pc_o         = r_fb_pc;
  assign fb_actual_o     = r_fb_actual;
  assign fb_conf_o       = r_fb_conf;
  assign fb_mispredict_o = r_fb_mispredict;
  assign fb_valid_o      = r_fb_valid;
  assign flush_o         = r_flush;
  assign count_o         = r_count;
  assign err_o           = r_err;
  assign pred_cnt_o      = r_pred_cnt;
  assign mispred_cnt_o   = r_mispred_cnt;

endmodule

// File: tb/tb_vp_feedback_tracker.sv
// Self-checking bench for vp_feedback_tracker: directed scenarios plus random
// traffic compared every cycle against a queue-based outcome model.
module tb_vp_feedback_tracker;

  localparam int DEPTH = 16;
  localparam int CW    = 8;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   res;
    logic [CW-1:0] conf;
    logic          used;
  } entry_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic [31:0]   predPc, predResult, exPc, exActual;
  logic [CW-1:0] predConf;
  logic          predValid, allocIn, exValid;
  logic          allocReady, fbMispredict, fbValid, flush, err;
  logic [31:0]   fbPc, fbActual, predCnt, mispredCnt;
  logic [CW-1:0] fbConf;
  logic [$clog2(DEPTH):0] count;

  int checkCount = 0;
  int failCount  = 0;

  entry_t        mq[$];
  logic          mFbValid, mFbMis, mFlush, mErr;
  logic [31:0]   mFbPc, mFbAct, mPredCnt, mMisCnt;
  logic [CW-1:0] mFbConf;

  vp_feedback_tracker #(.P_DEPTH(DEPTH), .P_CONF_THRES_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .pred_pc_i(predPc), .pred_result_i(predResult), .pred_conf_i(predConf),
    .pred_valid_i(predValid), .alloc_i(allocIn), .alloc_ready_o(allocReady),
    .ex_pc_i(exPc), .ex_actual_i(exActual), .ex_valid_i(exValid),
    .fb_pc_o(fbPc), .fb_actual_o(fbActual), .fb_conf_o(fbConf),
    .fb_mispredict_o(fbMispredict), .fb_valid_o(fbValid), .flush_o(flush),
    .count_o(count), .err_o(err), .pred_cnt_o(predCnt), .mispred_cnt_o(mispredCnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mFbValid = 0; mFbMis = 0; mFlush = 0; mErr = 0;
    mFbPc = 0; mFbAct = 0; mFbConf = 0; mPredCnt = 0; mMisCnt = 0;
  endtask

  // Outcome of one clock edge, derived from the tracker's rules on the in-order queue.
  task automatic modelStep();
    bit ready, mis, ret;
    entry_t h;
    ready = (mq.size() != DEPTH) && !mFlush;
    mis = 0;
    ret = 0;
    if (exValid) begin
      if (mq.size() == 0) begin
        mErr = 1;
      end else begin
        h = mq.pop_front();
        ret = 1;
        if (exPc != h.pc) mErr = 1;
        mFbPc = h.pc;
        mFbAct = exActual;
        mFbConf = h.conf;
        mis = h.used && (h.res != exActual);
        if (h.used && mPredCnt != 32'hFFFFFFFF) mPredCnt++;
        if (mis && mMisCnt != 32'hFFFFFFFF) mMisCnt++;
      end
    end
    if (allocIn && ready) mq.push_back('{predPc, predResult, predConf, predValid});
    if (mis) mq.delete();
    mFbValid = ret;
    mFbMis = mis;
    mFlush = mis;
  endtask

  task automatic checkOutput();
    checkVal("allocReady", allocReady, (mq.size() != DEPTH) && !mFlush);
    checkVal("count", count, mq.size());
    checkVal("fbValid", fbValid, mFbValid);
    checkVal("fbMispredict", fbMispredict, mFbMis);
    checkVal("flush", flush, mFlush);
    checkVal("err", err, mErr);
    checkVal("fbPc", fbPc, mFbPc);
    checkVal("fbActual", fbActual, mFbAct);
    checkVal("fbConf", fbConf, mFbConf);
    checkVal("predCnt", predCnt, mPredCnt);
    checkVal("mispredCnt", mispredCnt, mMisCnt);
  endtask

  task automatic applyStimulus(input logic a, input logic pv, input logic [31:0] ppc,
                               input logic [31:0] pres, input logic [CW-1:0] pconf,
                               input logic exv, input logic [31:0] expc, input logic [31:0] exact);
    allocIn = a; predValid = pv; predPc = ppc; predResult = pres; predConf = pconf;
    exValid = exv; exPc = expc; exActual = exact;
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic asyncReset();
    #2 rstN = 1'b0;
    #1;
    checkVal("rstCount", count, 0);
    checkVal("rstFbValid", fbValid, 0);
    checkVal("rstFlush", flush, 0);
    checkVal("rstErr", err, 0);
    checkVal("rstPredCnt", predCnt, 0);
    checkVal("rstFbPc", fbPc, 0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    checkOutput();
  endtask

  initial begin
    int pulses;
    logic [31:0] xpc;
    rstN = 1'b0;
    allocIn = 0; predValid = 0; predPc = 0; predResult = 0; predConf = 0;
    exValid = 0; exPc = 0; exActual = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    rstN = 1'b1;

    applyStimulus(1, 1, 32'h100, 32'd5, 8'hFF, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h100, 32'd5);
    checkVal("req35FbValid", fbValid, 1);
    checkVal("req35Mis", fbMispredict, 0);
    checkVal("req35Conf", fbConf, 32'hFF);
    checkVal("req35PredCnt", predCnt, 1);

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'h10 + 4*i, 32'd7, 8'h11, 0, 0, 0);
    checkVal("req36Count3", count, 3);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h10, 32'd9);
    checkVal("req36Mis", fbMispredict, 1);
    checkVal("req36Flush", flush, 1);
    checkVal("req36Count", count, 0);
    checkVal("req36MisCnt", mispredCnt, 1);
    checkVal("req36ReadyLow", allocReady, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("req36FlushEnd", flush, 0);
    checkVal("req36PredCnt", predCnt, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h14, 32'd7);
    checkVal("req38EmptyErr", err, 1);
    checkVal("req38EmptyNoFb", fbValid, 0);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 32'h1000 + 4*i, i, 8'h22, 0, 0, 0);
    checkVal("req37Full", count, 16);
    checkVal("req37ReadyLow", allocReady, 0);
    applyStimulus(1, 0, 32'h2000, 0, 0, 0, 0, 0);
    checkVal("req37Dropped", count, 16);
    applyStimulus(1, 0, 32'h2004, 0, 0, 1, 32'h1000, 32'd99);
    applyStimulus(1, 0, 32'h2008, 0, 0, 1, 32'h1004, 32'd99);
    checkVal("req37SameCycle", count, 15);
    pulses = 0;
    for (int i = 0; i < 40 && mq.size() > 0; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, mq[0].pc, 32'hABC);
      if (fbValid) pulses++;
    end
    checkVal("req37DrainPulses", pulses, 15);
    checkVal("req37Empty", count, 0);
    checkVal("req37NoMisCnt", mispredCnt, 1);

    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 32'h300 + i, 0, 0, 0, 0, 0);
    asyncReset();
    applyStimulus(1, 1, 32'h204, 32'd1, 8'h33, 0, 0, 0);
    checkVal("req39FirstAlloc", count, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h200, 32'd1);
    checkVal("req38PcErr", err, 1);
    checkVal("req38PcRetire", fbValid, 1);
    checkVal("req38FbPc", fbPc, 32'h204);

    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) asyncReset();
      if (mq.size() > 0 && $urandom_range(9) != 0) xpc = mq[0].pc;
      else xpc = $urandom_range(15);
      applyStimulus($urandom_range(9) < 7, $urandom_range(1), $urandom_range(15),
                    $urandom_range(3), CW'($urandom), $urandom_range(1), xpc,
                    $urandom_range(3));
    end

    $display("[TB] %0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
